ahci_dma_rd_seq: RTL and testbench

//  Sequencer for the DMA read-path word stuffer. Accepts a PRD stream of byte counts and tracks
//  16-bit words the stuffer consumes against each PRD. Gates stuffer input between PRDs, issues

---
 rtl/ahci_dma_rd_seq_if.sv | 38 +++
 rtl/ahci_dma_rd_seq.sv | 187 ++++++++++++++++++
 tb/tb_ahci_dma_rd_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahci_dma_rd_seq_if.sv
// rtl/ahci_dma_rd_seq_if.sv - PRD stream and stuffer handshake bundle for the DMA read sequencer
//
// Purpose: groups the PRD entry stream and the word-stuffer control/status
// signals seen by ahci_dma_rd_seq.
// Modports:
//   master : PRD fetch / stuffer side (drives prd_*, din_re, dm, flushed, dout_*)
//   slave  : sequencer side (drives prd_ready, din_en, flush)
// Signals:
//   prd_valid, prd_len[LEN_BITS], prd_last, prd_ready : PRD entry handshake
//   din_en, din_re, dm[2]                             : stuffer input gating / consumption
//   flush, flushed                                    : flush request / completion pulse
//   dout_vld, dout_re                                 : stuffer output activity (statistics)

interface ahci_dma_rd_seq_if #(
  parameter int LEN_BITS = 22
);
  logic                prd_valid;
  logic [LEN_BITS-1:0] prd_len;
  logic                prd_last;
  logic                prd_ready;
  logic                din_en;
  logic                din_re;
  logic [1:0]          dm;
  logic                flush;
  logic                flushed;
  logic                dout_vld;
  logic                dout_re;

  modport master (
    output prd_valid, prd_len, prd_last, din_re, dm, flushed, dout_vld, dout_re,
    input  prd_ready, din_en, flush
  );

  modport slave (
    input  prd_valid, prd_len, prd_last, din_re, dm, flushed, dout_vld, dout_re,
    output prd_ready, din_en, flush
  );
endinterface

// File: rtl/ahci_dma_rd_seq.sv
// rtl/ahci_dma_rd_seq.sv - DMA read-path word stuffer sequencer
//
// Purpose: takes PRD byte counts, tracks 16-bit words consumed by the stuffer
// against each PRD, gates stuffer input between PRDs, issues a flush after the
// last PRD, waits for flushed and reports done or error.
// Parameters:
//   LEN_BITS : PRD byte-count width (word count = prd_len[LEN_BITS-1:1])
//   FLUSH_TO : cycles allowed in WAIT for flushed before error (1..65535)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, abort    : begin transfer (IDLE only) / terminate from any state
//   bus (slave)     : PRD stream and stuffer handshake, see ahci_dma_rd_seq_if
//   busy            : state != IDLE
//   done            : one-cycle completion pulse
//   error           : sticky overrun / flush timeout flag
//   dword_cnt       : output dwords this transfer
// Configuration macro:
//   AHCI_DMA_RD_SEQ_STATS_EN : when defined, dword_cnt counts dout_vld & dout_re
//                              while busy (saturating); otherwise tied to 0.

module ahci_dma_rd_seq #(
  parameter int LEN_BITS = 22,
  parameter int FLUSH_TO = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  ahci_dma_rd_seq_if.slave     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          dword_cnt
);

  localparam int WL = LEN_BITS - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [WL-1:0]   words_left_q, words_left_d;
  logic            last_q, last_d;
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic            din_en_q, din_en_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic [WL-1:0]   len_words;
  logic [1:0]      consumed;
  logic [WL-1:0]   consumed_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      last_q       <= 1'b0;
      to_cnt_q     <= '0;
      din_en_q     <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      last_q       <= last_d;
      to_cnt_q     <= to_cnt_d;
      din_en_q     <= din_en_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    last_d       = last_q;
    to_cnt_d     = to_cnt_q;
    error_d      = error_q;
    len_words    = bus.prd_len[LEN_BITS-1:1];
    consumed     = bus.din_re ? ({1'b0, bus.dm[0]} + {1'b0, bus.dm[1]}) : 2'd0;
    consumed_ext = {{(WL-2){1'b0}}, consumed};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.prd_valid) begin
          if (len_words == '0) begin
            // Empty entry: nothing for the stuffer to consume
            if (bus.prd_last) state_d = S_FLUSH;
          end else begin
            words_left_d = len_words;
            last_d       = bus.prd_last;
            state_d      = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Overrun is checked before subtracting so words_left never wraps
        if (consumed_ext > words_left_q) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          words_left_d = words_left_q - consumed_ext;
          if (words_left_d == '0) state_d = last_q ? S_FLUSH : S_LOAD;
        end
      end
      S_FLUSH: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // flushed wins over a timeout landing in the same cycle
        if (bus.flushed) begin
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
          if (to_cnt_d == 16'(FLUSH_TO)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides everything, including a simultaneous start
    if (abort) begin
      state_d = S_IDLE;
      error_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it
    din_en_d = (state_d == S_RUN);
    flush_d  = (state_d == S_FLUSH);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  assign bus.prd_ready = (state_q == S_LOAD) && bus.prd_valid;
  assign bus.din_en    = din_en_q;
  assign bus.flush     = flush_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

`ifdef AHCI_DMA_RD_SEQ_STATS_EN
  logic [31:0] dword_cnt_q, dword_cnt_d;

  always_comb begin
    dword_cnt_d = dword_cnt_q;
    if (state_q == S_IDLE && start && !abort)
      dword_cnt_d = '0;
    else if (busy_q && bus.dout_vld && bus.dout_re && dword_cnt_q != 32'hffff_ffff)
      dword_cnt_d = dword_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dword_cnt_q <= '0;
    else     dword_cnt_q <= dword_cnt_d;
  end

  assign dword_cnt = dword_cnt_q;

  logic unused_bits;
  assign unused_bits = bus.prd_len[0];
`else
  assign dword_cnt = '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.prd_len[0], bus.dout_vld, bus.dout_re};
`endif

endmodule

// File: tb/tb_ahci_dma_rd_seq.sv
// tb/tb_ahci_dma_rd_seq.sv - directed self-checking bench for ahci_dma_rd_seq

module tb_ahci_dma_rd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic        busy, done, error;
  logic [31:0] dword_cnt;
  logic        busy_t, done_t, error_t;
  logic [31:0] dword_cnt_t;

  int vec = 0;
  int err = 0;

`ifdef AHCI_DMA_RD_SEQ_STATS_EN
  localparam logic [31:0] EXP_DW = 32'd3;
`else
  localparam logic [31:0] EXP_DW = 32'd0;
`endif

  ahci_dma_rd_seq_if #(.LEN_BITS(22)) bus ();
  ahci_dma_rd_seq_if #(.LEN_BITS(22)) bus_t ();

  assign bus_t.prd_valid = bus.prd_valid;
  assign bus_t.prd_len   = bus.prd_len;
  assign bus_t.prd_last  = bus.prd_last;
  assign bus_t.din_re    = bus.din_re;
  assign bus_t.dm        = bus.dm;
  assign bus_t.flushed   = bus.flushed;
  assign bus_t.dout_vld  = bus.dout_vld;
  assign bus_t.dout_re   = bus.dout_re;

  ahci_dma_rd_seq #(.LEN_BITS(22), .FLUSH_TO(255)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus.slave),
    .busy(busy), .done(done), .error(error), .dword_cnt(dword_cnt)
  );

  ahci_dma_rd_seq #(.LEN_BITS(22), .FLUSH_TO(4)) dut_to (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus_t.slave),
    .busy(busy_t), .done(done_t), .error(error_t), .dword_cnt(dword_cnt_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start         = 1'b0;
    abort         = 1'b0;
    bus.prd_valid = 1'b0;
    bus.prd_len   = '0;
    bus.prd_last  = 1'b0;
    bus.din_re    = 1'b0;
    bus.dm        = 2'd0;
    bus.flushed   = 1'b0;
    bus.dout_vld  = 1'b0;
    bus.dout_re   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    vec++; if ({busy, done, error, bus.flush, bus.din_en} !== 5'b0) begin err++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, error, bus.flush, bus.din_en}); end
    vec++; if (dword_cnt !== 32'd0) begin err++;
      $display("FAIL reset_dword_cnt: got %0d want 0", dword_cnt); end
    rst = 1'b0;
    tick();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd10; bus.prd_last = 1'b1;
    #1;
    vec++; if (bus.prd_ready !== 1'b1) begin err++;
      $display("FAIL reset_prd_ready: got %b want 1", bus.prd_ready); end
    tick();
    bus.prd_valid = 1'b0;
    vec++; if (bus.din_en !== 1'b1) begin err++;
      $display("FAIL reset_run_din_en: got %b want 1", bus.din_en); end
    rst = 1'b1;
    #1;
    vec++; if ({busy, bus.din_en, bus.flush} !== 3'b0) begin err++;
      $display("FAIL reset_async: got %b want 000", {busy, bus.din_en, bus.flush}); end
    tick();
    vec++; if ({busy, done, error, bus.flush, bus.din_en, bus.prd_ready} !== 6'b0) begin err++;
      $display("FAIL reset_midrun: got %b want 000000", {busy, done, error, bus.flush, bus.din_en, bus.prd_ready}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_prd();
    do_start();
    vec++; if (busy !== 1'b1) begin err++;
      $display("FAIL two_busy: got %b want 1", busy); end
    bus.prd_valid = 1'b1; bus.prd_len = 22'd8; bus.prd_last = 1'b0;
    #1;
    vec++; if (bus.prd_ready !== 1'b1) begin err++;
      $display("FAIL two_prd_ready0: got %b want 1", bus.prd_ready); end
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd3; bus.dout_vld = 1'b1; bus.dout_re = 1'b1;
    tick();
    tick();
    bus.din_re = 1'b0; bus.dout_vld = 1'b0; bus.dout_re = 1'b0;
    vec++; if ({bus.din_en, bus.flush} !== 2'b00) begin err++;
      $display("FAIL two_gap: got din_en/flush %b want 00", {bus.din_en, bus.flush}); end
    bus.prd_valid = 1'b1; bus.prd_len = 22'd4; bus.prd_last = 1'b1;
    #1;
    vec++; if (bus.prd_ready !== 1'b1) begin err++;
      $display("FAIL two_prd_ready1: got %b want 1", bus.prd_ready); end
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd3; bus.dout_vld = 1'b1; bus.dout_re = 1'b1;
    tick();
    bus.din_re = 1'b0; bus.dout_vld = 1'b0; bus.dout_re = 1'b0;
    vec++; if (bus.flush !== 1'b1) begin err++;
      $display("FAIL two_flush: got %b want 1", bus.flush); end
    tick();
    vec++; if (bus.flush !== 1'b0) begin err++;
      $display("FAIL two_flush_width: got %b want 0", bus.flush); end
    tick();
    tick();
    tick();
    vec++; if (done !== 1'b0) begin err++;
      $display("FAIL two_early_done: got %b want 0", done); end
    bus.flushed = 1'b1;
    tick();
    bus.flushed = 1'b0;
    vec++; if ({done, error} !== 2'b10) begin err++;
      $display("FAIL two_done: got done/error %b want 10", {done, error}); end
    vec++; if (dword_cnt !== EXP_DW) begin err++;
      $display("FAIL two_dword_cnt: got %0d want %0d", dword_cnt, EXP_DW); end
    tick();
    vec++; if ({done, busy} !== 2'b00) begin err++;
      $display("FAIL two_idle: got done/busy %b want 00", {done, busy}); end
    vec++; if (dword_cnt !== EXP_DW) begin err++;
      $display("FAIL two_dword_hold: got %0d want %0d", dword_cnt, EXP_DW); end
  endtask

  task automatic test_odd_split();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd6; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd1;
    tick();
    vec++; if ({bus.din_en, bus.flush} !== 2'b10) begin err++;
      $display("FAIL odd_after1: got din_en/flush %b want 10", {bus.din_en, bus.flush}); end
    bus.dm = 2'd3;
    tick();
    bus.dm = 2'd1;
    vec++; if ({bus.flush, bus.din_en} !== 2'b10) begin err++;
      $display("FAIL odd_flush: got flush/din_en %b want 10", {bus.flush, bus.din_en}); end
    tick();
    bus.din_re = 1'b0; bus.dm = 2'd0;
    vec++; if ({error, bus.flush, busy} !== 3'b001) begin err++;
      $display("FAIL odd_wait: got error/flush/busy %b want 001", {error, bus.flush, busy}); end
    bus.flushed = 1'b1;
    tick();
    bus.flushed = 1'b0;
    vec++; if ({done, error} !== 2'b10) begin err++;
      $display("FAIL odd_done: got done/error %b want 10", {done, error}); end
    tick();
  endtask

  task automatic test_overrun();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd2; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd3;
    tick();
    bus.din_re = 1'b0; bus.dm = 2'd0;
    vec++; if ({error, bus.din_en, bus.flush, done} !== 4'b1000) begin err++;
      $display("FAIL ovr_err: got error/din_en/flush/done %b want 1000", {error, bus.din_en, bus.flush, done}); end
    tick();
    vec++; if ({busy, error, bus.flush} !== 3'b010) begin err++;
      $display("FAIL ovr_idle: got busy/error/flush %b want 010", {busy, error, bus.flush}); end
    do_start();
    vec++; if ({busy, error} !== 2'b10) begin err++;
      $display("FAIL ovr_restart: got busy/error %b want 10", {busy, error}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_zero_len();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd0; bus.prd_last = 1'b0;
    #1;
    vec++; if (bus.prd_ready !== 1'b1) begin err++;
      $display("FAIL zero_ready: got %b want 1", bus.prd_ready); end
    tick();
    vec++; if ({busy, bus.din_en, bus.flush} !== 3'b100) begin err++;
      $display("FAIL zero_skip: got busy/din_en/flush %b want 100", {busy, bus.din_en, bus.flush}); end
    bus.prd_len = 22'd4; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    vec++; if (bus.din_en !== 1'b1) begin err++;
      $display("FAIL zero_run: got %b want 1", bus.din_en); end
    bus.din_re = 1'b1; bus.dm = 2'd1;
    tick();
    bus.dm = 2'd2;
    tick();
    bus.din_re = 1'b0; bus.dm = 2'd0;
    vec++; if (bus.flush !== 1'b1) begin err++;
      $display("FAIL zero_flush: got %b want 1", bus.flush); end
    tick();
    bus.flushed = 1'b1;
    tick();
    bus.flushed = 1'b0;
    vec++; if ({done, error} !== 2'b10) begin err++;
      $display("FAIL zero_done: got done/error %b want 10", {done, error}); end
    tick();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd1; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    vec++; if ({bus.flush, bus.din_en} !== 2'b10) begin err++;
      $display("FAIL zero_last_flush: got flush/din_en %b want 10", {bus.flush, bus.din_en}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_flush_timeout();
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd2; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd1;
    tick();
    bus.din_re = 1'b0; bus.dm = 2'd0;
    vec++; if (bus_t.flush !== 1'b1) begin err++;
      $display("FAIL to_flush: got %b want 1", bus_t.flush); end
    tick();
    tick();
    tick();
    tick();
    vec++; if ({error_t, done_t, busy_t} !== 3'b001) begin err++;
      $display("FAIL to_early: got error/done/busy %b want 001", {error_t, done_t, busy_t}); end
    tick();
    vec++; if ({error_t, done_t} !== 2'b10) begin err++;
      $display("FAIL to_error: got error/done %b want 10", {error_t, done_t}); end
    tick();
    vec++; if ({busy_t, error_t, done_t} !== 3'b010) begin err++;
      $display("FAIL to_sticky: got busy/error/done %b want 010", {busy_t, error_t, done_t}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec++; if ({error_t, error} !== 2'b00) begin err++;
      $display("FAIL to_abort_clear: got error_t/error %b want 00", {error_t, error}); end
    do_start();
    bus.prd_valid = 1'b1; bus.prd_len = 22'd2; bus.prd_last = 1'b1;
    tick();
    bus.prd_valid = 1'b0;
    bus.din_re = 1'b1; bus.dm = 2'd1;
    tick();
    bus.din_re = 1'b0; bus.dm = 2'd0;
    tick();
    abort = 1'b1; bus.flushed = 1'b1;
    tick();
    abort = 1'b0; bus.flushed = 1'b0;
    vec++; if ({busy_t, error_t, done_t, busy, done} !== 5'b0) begin err++;
      $display("FAIL abort_wait: got %b want 00000", {busy_t, error_t, done_t, busy, done}); end
    tick();
    vec++; if ({done_t, done} !== 2'b00) begin err++;
      $display("FAIL abort_no_done: got %b want 00", {done_t, done}); end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    vec++; if ({busy, busy_t} !== 2'b00) begin err++;
      $display("FAIL abort_beats_start: got %b want 00", {busy, busy_t}); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_two_prd();
    test_odd_split();
    test_overrun();
    test_zero_len();
    test_flush_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
